// File: rtl/button_event_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : joystick_pkg
// Purpose : Types and timing constants shared by the joystick-interface
//           blocks. Holds the button FSM state type, the default 100 MHz
//           timing constants and a small max helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package joystick_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    // Default timings at a 10 ns clock period.
    localparam int HOLD_500MS   = 50_000_000;
    localparam int REPEAT_100MS = 10_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : button_event_gen_if
// Purpose : Signal bundle between a debounced button source and the event
//           generator.
// Ports   : btn_in, repeat_en           - source -> generator
//           press/release/click/hold/repeat pulses, held - generator -> user
//           master modport: the side driving the button level
//           slave  modport: the event generator
// Revision: 1.0 - initial release
// ============================================================================
interface button_event_gen_if;

    logic btn_in;
    logic repeat_en;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic hold_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output btn_in, repeat_en,
        input  press_pulse, release_pulse, click_pulse,
               hold_pulse, repeat_pulse, held
    );

    modport slave (
        input  btn_in, repeat_en,
        output press_pulse, release_pulse, click_pulse,
               hold_pulse, repeat_pulse, held
    );

endinterface
`default_nettype wire

// File: rtl/button_event_gen_btn_edge_detect.sv
`default_nettype none
// ============================================================================
// Module  : btn_edge_detect
// Purpose : Registers a synchronous level and flags its rising and falling
//           edges combinationally. Reusable for any joystick line.
// Ports   : clk      - system clock
//           reset_n  - asynchronous active-low reset
//           btn_in   - level, synchronous to clk
//           rise     - btn_in high now, low last cycle
//           fall     - btn_in low now, high last cycle
// Revision: 1.0 - initial release
// ============================================================================
module btn_edge_detect (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic btn_in,
    output logic      rise,
    output logic      fall
);

    logic r_btn_q;

    // Clearing r_btn_q in reset makes a button already held at reset
    // release look like a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= btn_in;
        end
    end

    assign rise = btn_in & ~r_btn_q;
    assign fall = ~btn_in & r_btn_q;

endmodule
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
// Module  : button_event_gen
// Purpose : Turns a debounced button level into single-cycle events:
//           press, release, short click, long-press hold and auto-repeat
//           while held. All outputs are registered (1-cycle latency).
// Ports   : clk      - system clock
//           reset_n  - asynchronous active-low reset
//           bus      - button_event_gen_if.slave (btn_in, repeat_en in;
//                      event pulses and held level out)
// Params  : HOLD_CYCLES   - press length for a long hold (>= 2)
//           REPEAT_CYCLES - auto-repeat period while held (>= 2)
//           CNT_W         - derived counter width, leave at default
// Revision: 1.0 - initial release
// ============================================================================
module button_event_gen
    import joystick_pkg::*;
#(
    parameter int HOLD_CYCLES   = HOLD_500MS,
    parameter int REPEAT_CYCLES = REPEAT_100MS,
    parameter int CNT_W         = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES))
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    button_event_gen_if.slave bus
);

    localparam logic [CNT_W-1:0] c_hold_last   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_repeat_last = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

    logic       w_rise;
    logic       w_fall;

    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             r_release;
    logic             r_click;
    logic             r_hold;
    logic             r_repeat;
    logic             r_held;

    btn_edge_detect u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_in  (bus.btn_in),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    // Pulses default low every cycle; each branch raises at most the pulses
    // belonging to its transition, so press never coincides with any other
    // pulse and click never with hold/repeat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_hold    <= 1'b0;
            r_repeat  <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_hold    <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_press <= 1'b1;
                    end
                end
                PRESSED: begin
                    // A release on the threshold cycle is still a click.
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_release <= 1'b1;
                        r_click   <= 1'b1;
                    end else if (r_cnt == c_hold_last) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_hold  <= 1'b1;
                        r_held  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                HELD: begin
                    if (w_fall) begin
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                    end else if (r_cnt == c_repeat_last) begin
                        // Wrap regardless of repeat_en so the repeat phase
                        // is unaffected by toggling the enable.
                        r_cnt    <= '0;
                        r_repeat <= bus.repeat_en;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.click_pulse   = r_click;
    assign bus.hold_pulse    = r_hold;
    assign bus.repeat_pulse  = r_repeat;
    assign bus.held          = r_held;

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_event_gen
// Purpose : Directed, table-driven bench for button_event_gen with
//           HOLD_CYCLES=8, REPEAT_CYCLES=4. Output vector order is
//           {press, release, click, hold, repeat, held}.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_event_gen;

    localparam logic [5:0] c_none = 6'b000000;
    localparam logic [5:0] c_prs  = 6'b100000;
    localparam logic [5:0] c_rel  = 6'b010000;
    localparam logic [5:0] c_clk  = 6'b001000;
    localparam logic [5:0] c_hld  = 6'b000100;
    localparam logic [5:0] c_rep  = 6'b000010;
    localparam logic [5:0] c_lvl  = 6'b000001;

    typedef struct {
        logic       btn;
        logic       rep;
        logic [5:0] exp;
    } vec_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    vec_t tbl [0:255];
    int   n_vec;

    button_event_gen_if bus ();

    button_event_gen #(
        .HOLD_CYCLES   (8),
        .REPEAT_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] outs();
        return {bus.press_pulse, bus.release_pulse, bus.click_pulse,
                bus.hold_pulse, bus.repeat_pulse, bus.held};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic b, input logic r, input logic [5:0] e);
        tbl[n_vec].btn = b;
        tbl[n_vec].rep = r;
        tbl[n_vec].exp = e;
        n_vec++;
    endtask

    task automatic step(input logic b, input logic r);
        bus.btn_in    = b;
        bus.repeat_en = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_vec = 0;

        // ---- vector table ----
        // Continues from the post-reset press: drop the button.
        add(0, 0, c_rel | c_clk);
        add(0, 0, c_none);
        add(0, 0, c_none);
        // Short press, 3 cycles high.
        add(1, 0, c_prs);
        add(1, 0, c_none);
        add(1, 0, c_none);
        add(0, 0, c_rel | c_clk);
        add(0, 0, c_none);
        add(0, 0, c_none);
        // One-cycle press.
        add(1, 0, c_prs);
        add(0, 0, c_rel | c_clk);
        add(0, 0, c_none);
        // 20-cycle press with repeat on; the repeat due at cycle 20
        // coincides with the release and must be suppressed.
        for (int i = 0; i <= 20; i++) begin
            logic [5:0] e;
            e = c_none;
            if (i == 0)            e = c_prs;
            if (i == 8)            e = c_hld;
            if (i == 12 || i == 16) e = c_rep;
            if (i >= 8 && i <= 19) e = e | c_lvl;
            if (i == 20)           e = c_rel;
            add((i < 20), 1'b1, e);
        end
        add(0, 1, c_none);
        add(0, 1, c_none);
        // Same press with repeat disabled.
        for (int i = 0; i <= 20; i++) begin
            logic [5:0] e;
            e = c_none;
            if (i == 0)            e = c_prs;
            if (i == 8)            e = c_hld;
            if (i >= 8 && i <= 19) e = e | c_lvl;
            if (i == 20)           e = c_rel;
            add((i < 20), 1'b0, e);
        end
        add(0, 0, c_none);
        // Release exactly when the counter reaches HOLD_CYCLES-1.
        for (int i = 0; i <= 8; i++) begin
            add((i < 8), 1'b1, (i == 0) ? c_prs : ((i == 8) ? (c_rel | c_clk) : c_none));
        end
        for (int i = 0; i < 10; i++) add(0, 1, c_none);

        // ---- reset held with the button down ----
        reset_n       = 1'b0;
        bus.btn_in    = 1'b1;
        bus.repeat_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_out%0d", i), outs(), c_none);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("press_after_reset", outs(), c_prs);

        // ---- table ----
        for (int i = 0; i < n_vec; i++) begin
            step(tbl[i].btn, tbl[i].rep);
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // ---- asynchronous reset while HELD ----
        for (int i = 0; i < 10; i++) begin
            logic [5:0] e;
            e = (i == 0) ? c_prs : ((i == 8) ? (c_hld | c_lvl) : ((i == 9) ? c_lvl : c_none));
            step(1'b1, 1'b1);
            check($sformatf("pre_areset%0d", i), outs(), e);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_immediate", outs(), c_none);
        bus.btn_in = 1'b0;
        @(posedge clk);
        #1;
        check("areset_held_low", outs(), c_none);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            check($sformatf("no_release_after_reset%0d", i), outs(), c_none);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
